// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath blocks.
// FSM state encodings and the default word width.
package mips_pkg;

    localparam int WORD = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 word select with illegal-select flag.
// Ports: in_data (N packed words), sel, data (selected word), err.
module mux_n_comb
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int N     = 2,
    parameter int SELW  = 1
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   data,
    output logic               err
);

    // Default is the illegal case. A select holding X/Z never compares
    // equal to any code, so it falls through to zero data with err set.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 word mux with registered valid/ready output and 2-entry skid buffer.
// Ports: clk, rst_n (sync, active low), in_data/sel/in_valid/in_ready upstream,
//        out_data/out_valid/out_ready/sel_err downstream, err_count/clr_err.
module mux_n_pipe
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int N     = 2,
    parameter int SELW  = 1,
    parameter int ERRCW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err,
    output logic [ERRCW-1:0]   err_count,
    input  logic               clr_err
);

    logic [WIDTH-1:0] m_data;
    logic             m_err;

    logic [1:0]       state;
    logic [WIDTH-1:0] out_q;
    logic             out_err_q;
    logic [WIDTH-1:0] skid_q;
    logic             skid_err_q;
    logic             rst_q;

    logic             acc;
    logic             emit;
    logic             acc_err;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .data    (m_data),
        .err     (m_err)
    );

    // rst_q holds in_ready low for the cycle following a reset edge, so
    // in_ready depends on registers only and never on out_ready.
    assign in_ready  = (state != ST_TWO) && !rst_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_q;
    assign sel_err   = out_err_q && out_valid;

    assign acc     = in_valid && in_ready;
    assign emit    = out_valid && out_ready;
    assign acc_err = acc && m_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            out_q      <= '0;
            out_err_q  <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
            err_count  <= '0;
            rst_q      <= 1'b1;
        end else begin
            rst_q <= 1'b0;

            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        out_q     <= m_data;
                        out_err_q <= m_err;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && emit) begin
                        out_q     <= m_data;
                        out_err_q <= m_err;
                    end else if (acc) begin
                        skid_q     <= m_data;
                        skid_err_q <= m_err;
                        state      <= ST_TWO;
                    end else if (emit) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        out_q     <= skid_q;
                        out_err_q <= skid_err_q;
                        state     <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase

            // Clear wins over count, but an illegal accept in the same
            // cycle still registers as the first new error.
            if (clr_err) begin
                err_count <= ERRCW'(acc_err);
            end else if (acc_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed testbench for mux_n_pipe.
// Instance A: N=2, WIDTH=32. Instance B: N=4, WIDTH=16, SELW=3, ERRCW=2.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A
    logic [63:0] a_data;
    logic [0:0]  a_sel;
    logic        a_valid, a_ready_in, a_ovalid, a_oready, a_err, a_clr;
    logic [31:0] a_odata;
    logic [7:0]  a_cnt;

    // Instance B
    logic [63:0] b_data;
    logic [2:0]  b_sel;
    logic        b_valid, b_ready_in, b_ovalid, b_oready, b_err, b_clr;
    logic [15:0] b_odata;
    logic [1:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_x_data;
    logic        exp_x_err;

    mux_n_pipe #(
        .WIDTH (32), .N (2), .SELW (1), .ERRCW (8)
    ) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_data),
        .sel       (a_sel),
        .in_valid  (a_valid),
        .in_ready  (a_ready_in),
        .out_data  (a_odata),
        .out_valid (a_ovalid),
        .out_ready (a_oready),
        .sel_err   (a_err),
        .err_count (a_cnt),
        .clr_err   (a_clr)
    );

    mux_n_pipe #(
        .WIDTH (16), .N (4), .SELW (3), .ERRCW (2)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_data),
        .sel       (b_sel),
        .in_valid  (b_valid),
        .in_ready  (b_ready_in),
        .out_data  (b_odata),
        .out_valid (b_ovalid),
        .out_ready (b_oready),
        .sel_err   (b_err),
        .err_count (b_cnt),
        .clr_err   (b_clr)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;

    initial begin
        rst_n    = 1'b0;
        a_data   = {32'd2, 32'd30};
        a_sel    = 1'b0;
        a_valid  = 1'b1;
        a_oready = 1'b1;
        a_clr    = 1'b0;
        b_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        b_sel    = 3'd0;
        b_valid  = 1'b0;
        b_oready = 1'b1;
        b_clr    = 1'b0;

        // 1. reset with in_valid held high
        tick();
        check("rst1_in_ready", a_ready_in, 0);
        check("rst1_out_valid", a_ovalid, 0);
        check("rst1_err_count", a_cnt, 0);
        tick();
        check("rst2_in_ready", a_ready_in, 0);
        check("rst2_out_valid", a_ovalid, 0);
        check("rst2_b_err_count", b_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", a_ready_in, 1);
        check("post_rst_no_accept", a_ovalid, 0);

        // 2. legal selects back to back
        a_sel = 1'b0;
        tick();
        check("sel0_valid", a_ovalid, 1);
        check("sel0_data", a_odata, 30);
        check("sel0_err", a_err, 0);
        check("sel0_in_ready", a_ready_in, 1);
        a_sel = 1'b1;
        tick();
        check("sel1_data", a_odata, 2);
        check("sel1_in_ready", a_ready_in, 1);
        a_valid = 1'b0;
        tick();
        check("drain_valid", a_ovalid, 0);

        // 3a. illegal select on N=4
        b_sel   = 3'd5;
        b_valid = 1'b1;
        tick();
        check("ill5_data", b_odata, 0);
        check("ill5_err", b_err, 1);
        check("ill5_count", b_cnt, 1);
        b_sel = 3'd2;
        tick();
        check("leg2_data", b_odata, 16'h3333);
        check("leg2_err", b_err, 0);
        check("leg2_count", b_cnt, 1);
        b_valid = 1'b0;
        tick();

        // 3b. unknown select on N=2; a 2-state simulator sees a known code
        a_sel   = 1'bx;
        a_valid = 1'b1;
        if ($isunknown(a_sel) || a_sel > 1'b1) begin
            exp_x_data = 32'd0;
            exp_x_err  = 1'b1;
        end else begin
            exp_x_data = (a_sel == 1'b1) ? 32'd2 : 32'd30;
            exp_x_err  = 1'b0;
        end
        tick();
        check("selx_data", a_odata, exp_x_data);
        check("selx_err", a_err, exp_x_err);
        check("selx_no_x", $isunknown(a_odata), 0);
        check("selx_count", a_cnt, exp_x_err);
        a_valid = 1'b0;
        a_sel   = 1'b0;
        tick();

        // 4. backpressure into the skid buffer
        a_data   = {WB, WA};
        a_oready = 1'b0;
        a_valid  = 1'b1;
        a_sel    = 1'b0;
        tick();
        check("bp_a_data", a_odata, WA);
        check("bp_one_ready", a_ready_in, 1);
        a_sel = 1'b1;
        tick();
        check("bp_two_ready", a_ready_in, 0);
        check("bp_two_hold", a_odata, WA);
        a_data = {WB, 32'hDEAD_BEEF};
        a_sel  = 1'b0;
        tick();
        check("bp_stall_hold", a_odata, WA);
        check("bp_stall_valid", a_ovalid, 1);
        a_valid  = 1'b0;
        a_oready = 1'b1;
        tick();
        check("bp_emit_b", a_odata, WB);
        check("bp_emit_b_valid", a_ovalid, 1);
        tick();
        check("bp_empty", a_ovalid, 0);

        // 5. saturation on a 2-bit counter
        b_valid = 1'b0;
        b_clr   = 1'b1;
        tick();
        check("clr_only", b_cnt, 0);
        b_clr   = 1'b0;
        b_sel   = 3'd7;
        b_valid = 1'b1;
        tick();
        tick();
        check("sat_2", b_cnt, 2);
        tick();
        tick();
        tick();
        check("sat_5", b_cnt, 3);
        b_clr = 1'b1;
        tick();
        check("clr_and_ill", b_cnt, 1);
        b_clr   = 1'b0;
        b_valid = 1'b0;
        tick();

        // 6. reset while holding two words
        a_data   = {32'd2, 32'd30};
        a_oready = 1'b0;
        a_valid  = 1'b1;
        a_sel    = 1'b1;
        tick();
        tick();
        check("rst_mid_two", a_ready_in, 0);
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", a_ovalid, 0);
        check("rst_mid_ready", a_ready_in, 0);
        rst_n    = 1'b1;
        a_oready = 1'b1;
        a_sel    = 1'b0;
        tick();
        check("rst_mid_empty", a_ovalid, 0);
        tick();
        check("rst_mid_first_v", a_ovalid, 1);
        check("rst_mid_first_d", a_odata, 30);
        a_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
